// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: VGA scan-out owns fixed slots on a single-port RAM,
// and a pixel writer and a pixel reader share the remaining cycles round-robin.
module fb_port_arbiter #(
   parameter int SRC_W  = 160,
   parameter int SRC_H  = 120,
   parameter int ADDR_W = 15,
   parameter int DATA_W = 16
) (
   input  logic              vga_clk,
   input  logic              sys_rst_n,
   input  logic [9:0]        pix_x,
   input  logic [9:0]        pix_y,
   output logic [DATA_W-1:0] pix_data,
   input  logic              wr_valid,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_valid,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_ready,
   output logic              rd_rvalid,
   output logic [DATA_W-1:0] rd_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W-1:0] FB_WORDS  = ADDR_W'(SRC_W * SRC_H);
   localparam logic [9:0]        PIX_NONE  = 10'h3FF;
   localparam logic [9:0]        X_LAST    = 10'd639;
   localparam logic [9:0]        X_COL_END = 10'd636;
   localparam logic [9:0]        Y_LAST    = 10'd479;

   // Row-to-address scaling for the 160-pixel source stride, shift-and-add form.
   function automatic logic [ADDR_W-1:0] times_src_w(input logic [ADDR_W-1:0] r);
      return (r << 7) + (r << 5);
   endfunction

   logic              disp_pend_q, disp_pend_d;
   logic              rd_pend_q,   rd_pend_d;
   logic              rd_oor_q,    rd_oor_d;
   logic              prio_rd_q,   prio_rd_d;
   logic              rd_rvalid_q, rd_rvalid_d;
   logic [DATA_W-1:0] rd_rdata_q,  rd_rdata_d;
   logic [DATA_W-1:0] pix_data_q,  pix_data_d;

   logic              x_active, col_slot, pre_slot, disp_slot;
   logic [ADDR_W-1:0] py_a, px_a, next_row, disp_addr;
   logic              wr_oor, rd_oor, wr_gnt, rd_gnt;

   // NOTE: every signal assigned in an always_comb gets a value on every path
   // (here by straight-line code or defaults first), otherwise a latch is inferred.
   always_comb begin
      py_a      = ADDR_W'(pix_y);
      px_a      = ADDR_W'(pix_x);
      x_active  = (pix_x != PIX_NONE);
      col_slot  = x_active && (pix_x[1:0] == 2'd2) && (pix_x < X_COL_END);
      pre_slot  = x_active && (pix_x == X_LAST);
      disp_slot = col_slot || pre_slot;
      // Last visible line wraps the prefetch back to source row 0.
      next_row  = (pix_y == Y_LAST) ? '0 : ((py_a + ADDR_W'(1)) >> 2);
      disp_addr = col_slot ? times_src_w(py_a >> 2) + (px_a >> 2) + ADDR_W'(1)
                           : times_src_w(next_row);
   end

   always_comb begin
      wr_oor = (wr_addr >= FB_WORDS);
      rd_oor = (rd_addr >= FB_WORDS);
      wr_gnt = !disp_slot && wr_valid && (!rd_valid || !prio_rd_q);
      rd_gnt = !disp_slot && rd_valid && (!wr_valid || prio_rd_q);
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      wr_ready  = sys_rst_n && wr_gnt;
      rd_ready  = sys_rst_n && rd_gnt;
      if (!sys_rst_n) begin
         mem_en = 1'b0;
      end else if (disp_slot) begin
         mem_en   = 1'b1;
         mem_addr = disp_addr;
      end else if (wr_gnt && !wr_oor) begin
         mem_en    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = wr_addr;
         mem_wdata = wr_data;
      end else if (rd_gnt && !rd_oor) begin
         mem_en   = 1'b1;
         mem_addr = rd_addr;
      end
   end

   always_comb begin
      disp_pend_d = disp_slot;
      rd_pend_d   = rd_gnt;
      rd_oor_d    = rd_gnt && rd_oor;
      prio_rd_d   = prio_rd_q;
      if (wr_gnt) begin
         prio_rd_d = 1'b1;
      end else if (rd_gnt) begin
         prio_rd_d = 1'b0;
      end
      rd_rvalid_d = rd_pend_q;
      rd_rdata_d  = rd_rdata_q;
      if (rd_pend_q) begin
         rd_rdata_d = rd_oor_q ? '0 : mem_rdata;
      end
      pix_data_d = disp_pend_q ? mem_rdata : pix_data_q;
   end

   // NOTE: state flops use non-blocking assignment so every flop samples the
   // pre-edge value of its inputs, matching real register behaviour.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         disp_pend_q <= 1'b0;
         rd_pend_q   <= 1'b0;
         rd_oor_q    <= 1'b0;
         prio_rd_q   <= 1'b0;
         rd_rvalid_q <= 1'b0;
         rd_rdata_q  <= '0;
         pix_data_q  <= '0;
      end else begin
         disp_pend_q <= disp_pend_d;
         rd_pend_q   <= rd_pend_d;
         rd_oor_q    <= rd_oor_d;
         prio_rd_q   <= prio_rd_d;
         rd_rvalid_q <= rd_rvalid_d;
         rd_rdata_q  <= rd_rdata_d;
         pix_data_q  <= pix_data_d;
      end
   end

   assign pix_data  = pix_data_q;
   assign rd_rvalid = rd_rvalid_q;
   assign rd_rdata  = rd_rdata_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Randomized bench for fb_port_arbiter: a RAM model supplies mem_rdata and a
// spec-level model (image shadow, response queue, fetch pipeline) predicts outputs.
module tb_fb_port_arbiter;

   localparam int ADDR_W   = 15;
   localparam int DATA_W   = 16;
   localparam int FB_WORDS = 19200;

   logic              vga_clk = 1'b0;
   logic              sys_rst_n;
   logic [9:0]        pix_x, pix_y;
   logic [DATA_W-1:0] pix_data;
   logic              wr_valid, wr_ready, rd_valid, rd_ready, rd_rvalid;
   logic [ADDR_W-1:0] wr_addr, rd_addr, mem_addr;
   logic [DATA_W-1:0] wr_data, rd_rdata, mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_en, mem_we;

   always #20 vga_clk = ~vga_clk;

   fb_port_arbiter dut (
      .vga_clk   (vga_clk),
      .sys_rst_n (sys_rst_n),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_data  (pix_data),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_ready  (wr_ready),
      .rd_valid  (rd_valid),
      .rd_addr   (rd_addr),
      .rd_ready  (rd_ready),
      .rd_rvalid (rd_rvalid),
      .rd_rdata  (rd_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   function automatic logic [15:0] init_word(input int i);
      if (i == 161) return 16'hF800;
      return 16'((i * 40503) ^ (i >> 2));
   endfunction

   // Single-port RAM with one cycle of read latency; preloaded on the first edge.
   logic [15:0] ram [FB_WORDS];
   bit          ram_loaded = 1'b0;
   always @(posedge vga_clk) begin
      if (!ram_loaded) begin
         for (int i = 0; i < FB_WORDS; i++) ram[i] <= init_word(i);
         ram_loaded <= 1'b1;
      end else if (mem_en && int'(mem_addr) < FB_WORDS) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata    <= ram[mem_addr];
      end
   end

   typedef struct {
      int          due;
      logic [15:0] data;
   } resp_t;

   logic [15:0] shadow [FB_WORDS];
   resp_t       rq[$];
   bit          last_w;
   bit          f1;
   logic [15:0] v1, exp_pix, exp_rdata;
   bit          w_acc, r_acc, seen_wr_ready;
   int          cyc, n_cmp, n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, x=%0d y=%0d)",
                  tag, got, exp, cyc, pix_x, pix_y);
      end
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      if ($urandom_range(0, 49) == 0) return 15'(FB_WORDS + $urandom_range(0, 50));
      return 15'($urandom_range(0, FB_WORDS - 1));
   endfunction

   task automatic model_reset();
      rq.delete();
      last_w    = 1'b0;
      f1        = 1'b0;
      v1        = '0;
      exp_pix   = '0;
      exp_rdata = '0;
      w_acc     = 1'b0;
      r_acc     = 1'b0;
   endtask

   // mode 0: random traffic, 1: writer saturating, 2: both saturating, 3: inputs as preset
   task automatic run_cycle(input logic [9:0] x, input logic [9:0] y, input int mode);
      bit          disp, wg, rg, exp_rv, f_now;
      int          xi, yi, ea;
      logic [15:0] v_now;
      resp_t       r;
      pix_x = x;
      pix_y = y;
      if (mode != 3) begin
         if (!wr_valid || w_acc) begin
            wr_valid = (mode == 1 || mode == 2) ? 1'b1 : ($urandom_range(0, 2) == 0);
            wr_addr  = rand_addr();
            wr_data  = 16'($urandom);
         end
         if (!rd_valid || r_acc) begin
            rd_valid = (mode == 2) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 2) == 0);
            rd_addr  = rand_addr();
         end
      end
      #1;
      seen_wr_ready = wr_ready;
      xi    = int'(x);
      yi    = int'(y);
      disp  = (x != 10'h3FF) && (((xi % 4) == 2 && xi < 636) || xi == 639);
      wg    = 1'b0;
      rg    = 1'b0;
      f_now = 1'b0;
      v_now = '0;
      if (disp) begin
         if (xi == 639) ea = (yi == 479) ? 0 : ((yi + 1) / 4) * 160;
         else           ea = (yi / 4) * 160 + xi / 4 + 1;
         check("disp_en",   mem_en,   1);
         check("disp_we",   mem_we,   0);
         check("disp_addr", mem_addr, ea);
         check("disp_wr_ready", wr_ready, 0);
         check("disp_rd_ready", rd_ready, 0);
         f_now = 1'b1;
         v_now = shadow[ea];
      end else begin
         wg = wr_valid && (!rd_valid || !last_w);
         rg = rd_valid && (!wr_valid || last_w);
         check("wr_ready", wr_ready, wg);
         check("rd_ready", rd_ready, rg);
         if (wg) begin
            if (int'(wr_addr) < FB_WORDS) begin
               check("wr_en",    mem_en,    1);
               check("wr_we",    mem_we,    1);
               check("wr_addr",  mem_addr,  wr_addr);
               check("wr_wdata", mem_wdata, wr_data);
               shadow[wr_addr] = wr_data;
            end else begin
               check("wr_oor_en", mem_en, 0);
            end
            last_w = 1'b1;
         end else if (rg) begin
            if (int'(rd_addr) < FB_WORDS) begin
               check("rd_en",   mem_en,   1);
               check("rd_we",   mem_we,   0);
               check("rd_addr", mem_addr, rd_addr);
               rq.push_back('{due: cyc + 2, data: shadow[rd_addr]});
            end else begin
               check("rd_oor_en", mem_en, 0);
               rq.push_back('{due: cyc + 2, data: 16'h0000});
            end
            last_w = 1'b0;
         end else begin
            check("idle_en", mem_en, 0);
            check("idle_we", mem_we, 0);
         end
      end
      w_acc = wg;
      r_acc = rg;
      @(posedge vga_clk);
      #1;
      cyc++;
      exp_rv = (rq.size() > 0) && (rq[0].due == cyc);
      if (exp_rv) begin
         r         = rq.pop_front();
         exp_rdata = r.data;
      end
      check("rd_rvalid", rd_rvalid, exp_rv);
      check("rd_rdata",  rd_rdata,  exp_rdata);
      if (f1) exp_pix = v1;
      f1 = f_now;
      v1 = v_now;
      check("pix_data", pix_data, exp_pix);
   endtask

   task automatic run_line(input logic [9:0] y, input int mode_act, input int mode_blank);
      int accepted;
      accepted = 0;
      for (int x = 0; x < 640; x++) begin
         run_cycle(10'(x), y, mode_act);
         accepted += int'(seen_wr_ready);
      end
      if (mode_act == 1) check("wr_accepts_per_line", accepted, 480);
      for (int i = 0; i < 160; i++) run_cycle(10'h3FF, 10'h3FF, mode_blank);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      for (int i = 0; i < FB_WORDS; i++) shadow[i] = init_word(i);
      model_reset();

      sys_rst_n = 1'b0;
      pix_x     = 10'd2;
      pix_y     = 10'd0;
      wr_valid  = 1'b1;
      wr_addr   = 15'd5;
      wr_data   = 16'h1234;
      rd_valid  = 1'b1;
      rd_addr   = 15'd7;
      repeat (3) @(posedge vga_clk);
      #1;
      check("rst_pix_data",  pix_data,  0);
      check("rst_rd_rvalid", rd_rvalid, 0);
      check("rst_rd_rdata",  rd_rdata,  0);
      check("rst_mem_en",    mem_en,    0);
      check("rst_mem_we",    mem_we,    0);
      check("rst_mem_addr",  mem_addr,  0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_wr_ready",  wr_ready,  0);
      check("rst_rd_ready",  rd_ready,  0);
      @(negedge vga_clk);
      wr_valid  = 1'b0;
      rd_valid  = 1'b0;
      pix_x     = 10'h3FF;
      pix_y     = 10'h3FF;
      sys_rst_n = 1'b1;

      run_line(10'd0,   0, 1);
      run_line(10'd3,   1, 2);
      run_line(10'd4,   0, 2);
      run_line(10'd5,   0, 0);
      run_line(10'd478, 0, 0);
      run_line(10'd479, 0, 2);
      run_line(10'd0,   0, 0);

      // Out-of-range requests while blanking, then idle cycles for the late response.
      for (int i = 0; i < 4; i++) run_cycle(10'h3FF, 10'h3FF, 3);
      wr_valid = 1'b1; wr_addr = 15'd19200; wr_data = 16'hBEEF; rd_valid = 1'b0;
      run_cycle(10'h3FF, 10'h3FF, 3);
      wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 15'd19200;
      run_cycle(10'h3FF, 10'h3FF, 3);
      rd_valid = 1'b0;
      for (int i = 0; i < 4; i++) run_cycle(10'h3FF, 10'h3FF, 3);

      // Reset asserted while a read response is pending.
      rd_valid = 1'b1; rd_addr = 15'd100;
      run_cycle(10'h3FF, 10'h3FF, 3);
      pix_x     = 10'd2;
      pix_y     = 10'd0;
      sys_rst_n = 1'b0;
      #1;
      check("midrst_pix_data",  pix_data,  0);
      check("midrst_rd_rvalid", rd_rvalid, 0);
      check("midrst_rd_rdata",  rd_rdata,  0);
      check("midrst_mem_en",    mem_en,    0);
      check("midrst_rd_ready",  rd_ready,  0);
      check("midrst_wr_ready",  wr_ready,  0);
      model_reset();
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      rd_valid  = 1'b0;
      wr_valid  = 1'b0;
      pix_x     = 10'h3FF;
      pix_y     = 10'h3FF;
      sys_rst_n = 1'b1;
      for (int i = 0; i < 4; i++) run_cycle(10'h3FF, 10'h3FF, 3);
      run_line(10'd8, 0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
